// File: rtl/bg_rom_pkg.sv
// Shared types and constants for the background ROM port arbiter.
package bg_rom_pkg;

    localparam int unsigned BG_ROM_DEPTH = 19200;
    localparam int unsigned BG_ROM_W     = 160;
    localparam int unsigned BG_ADDR_W    = 15;
    localparam int unsigned BG_DATA_W    = 16;
    localparam int unsigned BG_PIX_W     = 12;
    localparam int unsigned BG_ID_W      = 3;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_DISP,
        ACC_BLANK,
        ACC_REQ
    } access_kind_e;

    // Stage-1 record of what was decided on the ROM port last cycle.
    typedef struct packed {
        access_kind_e         kind;
        logic [BG_ID_W-1:0]   id;
        logic                 oor;
    } s1_entry_t;

    // Keep the top four bits of each RGB565 channel.
    function automatic logic [BG_PIX_W-1:0] rgb565_to_444(input logic [BG_DATA_W-1:0] c);
        return {c[15:12], c[10:7], c[4:1]};
    endfunction

endpackage

// File: rtl/bg_rom_port_arbiter_rr_arbiter.sv
// Generic N-way round-robin grant; pointer advances past each winner.
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      idx;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win_o = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req_i[IDX_W'(idx)]) begin
                found = 1'b1;
                win_o = IDX_W'(idx);
            end
        end
        any_o = found && en_i;
        gnt_o = any_o ? (N'(1) << win_o) : '0;
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = (win_o == IDX_W'(N - 1)) ? '0 : IDX_W'(win_o + 1'b1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bg_rom_port_arbiter.sv
// Background ROM read-port arbiter: VGA scan first, round-robin requesters on idle cycles.
module bg_rom_port_arbiter
    import bg_rom_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ROM_DEPTH = BG_ROM_DEPTH,
    parameter int unsigned SCALE_SH  = 2,
    parameter int unsigned ROM_W     = BG_ROM_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pix_tick,
    input  logic                         disp_en,
    input  logic [9:0]                   x_pixel,
    input  logic [9:0]                   y_pixel,
    output logic [BG_PIX_W-1:0]          disp_pixel,
    output logic                         disp_valid,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BG_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [BG_DATA_W-1:0]         rsp_data,
    output logic [BG_ADDR_W-1:0]         rom_addr,
    output logic                         rom_rd_en,
    input  logic [BG_DATA_W-1:0]         rom_data
);

    localparam int unsigned AW    = BG_ADDR_W;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             disp_hit_c, blank_c, arb_en_c, grant_c, oor_c;
    logic [IDX_W-1:0] win_c;
    logic [AW-1:0]    sel_addr_c, disp_addr_c;

    s1_entry_t                s1_q, s1_d;
    logic [BG_PIX_W-1:0]      disp_pixel_q, disp_pixel_d;
    logic                     disp_valid_q, disp_valid_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [BG_DATA_W-1:0]     rsp_data_q, rsp_data_d;

    assign disp_hit_c = pix_tick && disp_en;
    assign blank_c    = pix_tick && !disp_en;
    assign arb_en_c   = !reset && !pix_tick;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .reset (reset),
        .en_i  (arb_en_c),
        .req_i (req_valid),
        .gnt_o (req_ready),
        .win_o (win_c),
        .any_o (grant_c)
    );

    // Winner's address, display address, and the port drive for this cycle.
    always_comb begin
        sel_addr_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_c == IDX_W'(i)) begin
                sel_addr_c = req_addr[AW*i +: AW];
            end
        end
        oor_c       = sel_addr_c >= AW'(ROM_DEPTH);
        disp_addr_c = AW'(y_pixel >> SCALE_SH) * AW'(ROM_W) + AW'(x_pixel >> SCALE_SH);
        rom_addr    = disp_hit_c ? disp_addr_c : (grant_c ? sel_addr_c : '0);
        rom_rd_en   = !reset && (disp_hit_c || (grant_c && !oor_c));
    end

    // Stage-1 decision record.
    always_comb begin
        s1_d = '0;
        if (disp_hit_c) begin
            s1_d.kind = ACC_DISP;
        end else if (blank_c) begin
            s1_d.kind = ACC_BLANK;
        end else if (grant_c) begin
            s1_d.kind = ACC_REQ;
            s1_d.id   = BG_ID_W'(win_c);
            s1_d.oor  = oor_c;
        end
    end

    // Stage-2 output formation from the ROM word; data holds when idle.
    always_comb begin
        disp_pixel_d = disp_pixel_q;
        disp_valid_d = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        case (s1_q.kind)
            ACC_DISP: begin
                disp_valid_d = 1'b1;
                disp_pixel_d = rgb565_to_444(rom_data);
            end
            ACC_BLANK: begin
                disp_valid_d = 1'b1;
                disp_pixel_d = '0;
            end
            ACC_REQ: begin
                rsp_valid_d = NUM_REQ'(1) << s1_q.id;
                rsp_data_d  = s1_q.oor ? '0 : rom_data;
            end
            default: ;
        endcase
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= '0;
            disp_pixel_q <= '0;
            disp_valid_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            s1_q         <= s1_d;
            disp_pixel_q <= disp_pixel_d;
            disp_valid_q <= disp_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign disp_pixel = disp_pixel_q;
    assign disp_valid = disp_valid_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_bg_rom_port_arbiter.sv
// Randomized self-checking bench for bg_rom_port_arbiter against a behavioural model.
module tb_bg_rom_port_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_tick, disp_en;
    logic [9:0]    x_pixel, y_pixel;
    logic [11:0]   disp_pixel;
    logic          disp_valid;
    logic [N-1:0]  req_valid, req_ready, rsp_valid;
    logic [N*15-1:0] req_addr;
    logic [15:0]   rsp_data;
    logic [14:0]   rom_addr;
    logic          rom_rd_en;
    logic [15:0]   rom_data;

    bg_rom_port_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_tick   (pix_tick),
        .disp_en    (disp_en),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .disp_pixel (disp_pixel),
        .disp_valid (disp_valid),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rom_addr   (rom_addr),
        .rom_rd_en  (rom_rd_en),
        .rom_data   (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input int unsigned a);
        if (a == 162) return 16'hF81F;
        return 16'((a * 40503) ^ (a >> 2) ^ 32'h1234);
    endfunction

    // ROM with registered output; garbage when not read.
    always @(posedge clk) rom_data <= rom_rd_en ? rom_word(32'(rom_addr)) : 16'hDEAD;

    function automatic logic [11:0] to444(input logic [15:0] w);
        int r, g, b;
        r = int'(w) / 2048;
        g = (int'(w) / 32) % 64;
        b = int'(w) % 32;
        return 12'((r / 2) * 256 + (g / 4) * 16 + (b / 2));
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          kind;   // 0 none, 1 display, 2 blank, 3 requester
        int          id;
        logic [15:0] data;
    } dec_t;

    int          ptr;
    logic [N-1:0] rq_v;
    int          rq_a [N];
    dec_t        s1, outd;
    logic [11:0] hold_pix;
    logic [15:0] hold_rsp;

    task automatic cycle(input logic tick, input logic en, input int x, input int y, input logic rst);
        dec_t         cur;
        int           win, idx, exp_addr;
        logic [N-1:0] exp_rdy;
        logic         exp_rd;
        reset    = rst;
        pix_tick = tick;
        disp_en  = en;
        x_pixel  = 10'(x);
        y_pixel  = 10'(y);
        req_valid = rq_v;
        for (int i = 0; i < N; i++) req_addr[15*i +: 15] = 15'(rq_a[i]);
        #1;
        cur = '{0, 0, 16'h0};
        exp_rdy = '0;
        exp_rd = 1'b0;
        exp_addr = 0;
        if (!rst) begin
            if (tick && en) begin
                exp_addr = (y / 4) * 160 + x / 4;
                exp_rd = 1'b1;
                cur = '{1, 0, 16'(to444(rom_word(exp_addr)))};
            end else if (tick) begin
                cur = '{2, 0, 16'h0};
            end else begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (win < 0 && rq_v[idx]) win = idx;
                end
                if (win >= 0) begin
                    exp_rdy = N'(1) << win;
                    cur.kind = 3;
                    cur.id = win;
                    if (rq_a[win] < 19200) begin
                        exp_rd = 1'b1;
                        exp_addr = rq_a[win];
                        cur.data = rom_word(exp_addr);
                    end
                    ptr = (win + 1) % N;
                    rq_v[win] = 1'b0;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rom_rd_en", 32'(rom_rd_en), 32'(exp_rd));
        if (exp_rd) chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        @(posedge clk);
        #1;
        if (rst) begin
            outd = '{0, 0, 16'h0};
            s1 = '{0, 0, 16'h0};
            hold_pix = '0;
            hold_rsp = '0;
            ptr = 0;
        end else begin
            outd = s1;
            s1 = cur;
            if (outd.kind == 1 || outd.kind == 2) hold_pix = outd.data[11:0];
            if (outd.kind == 3) hold_rsp = outd.data;
        end
        chk("disp_valid", 32'(disp_valid), (outd.kind == 1 || outd.kind == 2) ? 32'd1 : 32'd0);
        chk("disp_pixel", 32'(disp_pixel), 32'(hold_pix));
        chk("rsp_valid", 32'(rsp_valid), outd.kind == 3 ? 32'(N'(1) << outd.id) : 32'd0);
        chk("rsp_data", 32'(rsp_data), 32'(hold_rsp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        ptr = 0;
        rq_v = '0;
        for (int i = 0; i < N; i++) rq_a[i] = 0;
        s1 = '{0, 0, 16'h0};
        outd = '{0, 0, 16'h0};
        hold_pix = '0;
        hold_rsp = '0;

        // Reset state
        cycle(1'b0, 1'b0, 0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1);

        // Display read at (8,4) -> address 162, pixel F0F
        cycle(1'b1, 1'b1, 8, 4, 1'b0);
        idle(1);
        chk("tp1_pix", 32'(disp_pixel), 32'h0F0F);
        idle(1);

        // All three requesters held: grants 0,1,2,0
        for (int c = 0; c < 4; c++) begin
            rq_v = 3'b111;
            rq_a[0] = 100; rq_a[1] = 200; rq_a[2] = 300;
            idle(1);
        end
        rq_v = '0;
        idle(2);

        // Tick collides with requester 1
        rq_v = 3'b010;
        rq_a[1] = 4321;
        cycle(1'b1, 1'b1, 639, 479, 1'b0);
        idle(3);

        // Out-of-range address on requester 2
        rq_v = 3'b100;
        rq_a[2] = 19200;
        idle(1);
        rq_v = '0;
        idle(2);
        chk("oor_rsp", 32'(rsp_data), 32'h0);

        // Blanked tick
        cycle(1'b1, 1'b0, 100, 100, 1'b0);
        idle(2);

        // Grant then reset: the response is dropped and the pointer returns to 0
        rq_v = 3'b001;
        rq_a[0] = 555;
        idle(1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1);
        idle(3);
        rq_v = 3'b111;
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    rq_v[i] = 1'b1;
                    rq_a[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(19200, 32767))
                                                          : int'($urandom_range(0, 19199));
                end
            end
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                  $urandom_range(0, 199) == 0);
        end
        rq_v = '0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bg_rom_port_arbiter.md
Name: bg_rom_port_arbiter

Overview:
- Shares the single synchronous read port of the background image ROM (160x120, 16-bit RGB565 words, 19200 entries) between two kinds of requester.
- The VGA scan path has absolute priority on every pixel tick.
- NUM_REQ game-logic requesters (e.g. splash-colour sampling, hit effects) get round-robin access on the remaining idle cycles.
- Sits between the VGA timing and sprite-compositing logic and the background ROM instance. Converts display reads to RGB444 and returns raw 16-bit words to the requesters.

Parameters:
- NUM_REQ, 3, number of secondary requesters (1..8).
- ROM_DEPTH, 19200, valid ROM word count; addresses >= this are out of range.
- SCALE_SH, 2, right shift from screen coordinates to ROM coordinates (4x upscale).
- ROM_W, 160, ROM row width in words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_tick  in  1  one-cycle strobe per display pixel (every 4th clk)
- disp_en  in  1  display active area; qualifies pix_tick
- x_pixel  in  10  current screen x (0..639)
- y_pixel  in  10  current screen y (0..479)
- disp_pixel  out  12  RGB444 background pixel {R[4:1],G[5:2],B[4:1]} of RGB565
- disp_valid  out  1  disp_pixel updated this cycle
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*15  flattened word addresses, requester i at [15*i+:15]
- req_ready  out  NUM_REQ  one-hot grant; request accepted when valid and ready
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_data  out  16  response word, shared by all requesters
- rom_addr  out  15  ROM read address (combinational from the current-cycle decision)
- rom_rd_en  out  1  ROM read enable
- rom_data  in  16  ROM registered output, valid the cycle after rom_addr/rom_rd_en

Behaviour:
- Reset: disp_pixel=0, disp_valid=0, rsp_valid=0, rsp_data=0, rr_ptr=0, pipeline stages cleared.
- While reset is asserted: req_ready=0, rom_rd_en=0.
- Cycle decision (cycle t), strict priority:
  - pix_tick && disp_en: DISPLAY read.
    - rom_addr = (y_pixel>>SCALE_SH)*ROM_W + (x_pixel>>SCALE_SH).
    - Compute at 15 bits with no truncation; the max value 19199 fits.
    - All req_ready=0.
  - pix_tick && !disp_en: DISPLAY_BLANK.
    - No ROM read.
    - disp_pixel=0 delivered with the same latency as a real read.
    - Requesters still blocked this cycle.
  - Otherwise, if any req_valid: grant the first set bit searching from rr_ptr upward with wrap.
    - req_ready is one-hot to the winner only.
    - rr_ptr <= winner+1 mod NUM_REQ.
  - Otherwise idle: rom_rd_en=0, rr_ptr unchanged.
- Out-of-range request (req_addr >= ROM_DEPTH):
  - Accepted normally and rr_ptr advances.
  - No ROM read.
  - rsp_data=16'h0000 at normal latency.
- req_ready is combinational from req_valid, pix_tick and rr_ptr. Requesters must hold req_valid/req_addr stable until accepted.
- Pipeline:
  - Stage 1 register captures kind {NONE, DISP, BLANK, REQ}, requester id, and out-of-range flag.
  - Stage 2 consumes rom_data on cycle t+1 and registers the outputs.
  - Latency: decision at cycle t gives disp_valid/rsp_valid high on cycle t+2 for exactly one cycle. Fully pipelined, one access per cycle.
  - disp_pixel and rsp_data hold their last value when not updated.
- Simultaneous display tick and requests: display wins; requests stay pending without loss. Worst-case requester wait is 1 tick cycle + (NUM_REQ-1) grants.
- Reset mid-operation: in-flight stage-1/2 entries are discarded; no rsp_valid is issued for them. Requesters must re-issue.
- Ticks closer than 2 cycles apart are legal; each is served.

Decomposition:
- Package bg_rom_pkg holds:
  - typedef enum access_kind_e {ACC_NONE, ACC_DISP, ACC_BLANK, ACC_REQ}
  - constants BG_ROM_DEPTH=19200, BG_ROM_W=160, BG_ADDR_W=15
  - function rgb565_to_444
- One natural sub-module, rr_arbiter, a generic NUM_REQ round-robin grant with pointer, reused elsewhere.

Test Plan:
- Reset then pix_tick, disp_en=1, x=8, y=4 -> rom_addr=162, rom_rd_en=1. Model ROM returns 16'hF81F. Two cycles later disp_valid=1, disp_pixel=12'hF0F.
- req_valid=3'b111 held, no ticks, rr_ptr=0 -> grants on consecutive cycles 0,1,2,0. Each rsp_valid one-hot 2 cycles after its grant with the correct ROM word.
- pix_tick coincides with req_valid[1] -> req_ready=0 that cycle; requester 1 granted next cycle; display response precedes requester response by one cycle.
- req_addr=19200 on requester 2 -> accepted, rom_rd_en=0, rsp_valid[2] after 2 cycles with rsp_data=0.
- pix_tick, disp_en=0 -> rom_rd_en=0; disp_valid after 2 cycles with disp_pixel=0.
- Grant requester 0, assert reset on the next cycle for one cycle -> no rsp_valid ever issued; all outputs 0; rr_ptr=0 afterwards.
